// File: rtl/bscan_pkg.sv
// Shared TAP controller types and constants: state encoding, opcodes, boundary cell map.
// BSCAN_IDCODE_EN selects whether IDCODE is the instruction loaded on reset/TLR.
package bscan_pkg;

    localparam int IR_LEN  = 2;
    localparam int BSR_LEN = 5;
    localparam int ID_LEN  = 32;

    // Boundary cell positions; cell 0 sits nearest TDO
    localparam int CELL_A = 0;
    localparam int CELL_B = 1;
    localparam int CELL_C = 2;
    localparam int CELL_X = 3;
    localparam int CELL_Y = 4;

    typedef enum logic [3:0] {
        ST_EXIT2_DR  = 4'h0,
        ST_EXIT1_DR  = 4'h1,
        ST_SHIFT_DR  = 4'h2,
        ST_PAUSE_DR  = 4'h3,
        ST_SEL_IR    = 4'h4,
        ST_UPDATE_DR = 4'h5,
        ST_CAP_DR    = 4'h6,
        ST_SEL_DR    = 4'h7,
        ST_EXIT2_IR  = 4'h8,
        ST_EXIT1_IR  = 4'h9,
        ST_SHIFT_IR  = 4'hA,
        ST_PAUSE_IR  = 4'hB,
        ST_RTI       = 4'hC,
        ST_UPDATE_IR = 4'hD,
        ST_CAP_IR    = 4'hE,
        ST_TLR       = 4'hF
    } tap_state_t;

    localparam logic [IR_LEN-1:0] OP_EXTEST  = IR_LEN'(0);
    localparam logic [IR_LEN-1:0] OP_SAMPLE  = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] OP_IDCODE  = IR_LEN'(2);
    localparam logic [IR_LEN-1:0] OP_BYPASS  = {IR_LEN{1'b1}};
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

`ifdef BSCAN_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_RESET = OP_IDCODE;
`else
    localparam logic [IR_LEN-1:0] IR_RESET = OP_BYPASS;
`endif

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP sequencer driven by TMS, with per-state capture/shift/update strobes.
module tap_fsm
    import bscan_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       tlr_next_o,
    output logic       cap_dr_o,
    output logic       shift_dr_o,
    output logic       upd_dr_o,
    output logic       cap_ir_o,
    output logic       shift_ir_o,
    output logic       upd_ir_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:       state_d = tms_i ? ST_TLR       : ST_RTI;
            ST_RTI:       state_d = tms_i ? ST_SEL_DR    : ST_RTI;
            ST_SEL_DR:    state_d = tms_i ? ST_SEL_IR    : ST_CAP_DR;
            ST_CAP_DR:    state_d = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:  state_d = tms_i ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:  state_d = tms_i ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:  state_d = tms_i ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:  state_d = tms_i ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR: state_d = tms_i ? ST_SEL_DR    : ST_RTI;
            ST_SEL_IR:    state_d = tms_i ? ST_TLR       : ST_CAP_IR;
            ST_CAP_IR:    state_d = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:  state_d = tms_i ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:  state_d = tms_i ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:  state_d = tms_i ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:  state_d = tms_i ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR: state_d = tms_i ? ST_SEL_DR    : ST_RTI;
            default:      state_d = ST_TLR;
        endcase
    end

    assign state_o    = state_q;
    // Asserted on the edge that lands in (or stays in) TLR, so the reload happens on entry
    assign tlr_next_o = (state_d == ST_TLR);
    assign cap_dr_o   = (state_q == ST_CAP_DR);
    assign shift_dr_o = (state_q == ST_SHIFT_DR);
    assign upd_dr_o   = (state_q == ST_UPDATE_DR);
    assign cap_ir_o   = (state_q == ST_CAP_IR);
    assign shift_ir_o = (state_q == ST_SHIFT_IR);
    assign upd_ir_o   = (state_q == ST_UPDATE_IR);

endmodule

// File: rtl/bscan_tap_ctrl.sv
// Boundary-scan TAP controller around the XorNor core: IR, bypass, BSR and EXTEST pin muxing.
// Define BSCAN_IDCODE_EN to add the 32-bit ID register and make IDCODE the reset instruction.
module bscan_tap_ctrl
    import bscan_pkg::*;
#(
    parameter logic [ID_LEN-1:0] IDCODE_VAL = 32'h1000_0A5D
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         TMS,
    input  logic         TDI,
    output logic         TDO,
    output logic         TDO_En,
    input  logic [2:0]   PinIn,
    output logic [2:0]   CoreIn,
    input  logic [1:0]   CoreOut,
    output logic [1:0]   PinOut,
    output logic [3:0]   TapState
);

    tap_state_t state;
    logic tlr_next, cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir;

    tap_fsm u_fsm (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .tms_i      (TMS),
        .state_o    (state),
        .tlr_next_o (tlr_next),
        .cap_dr_o   (cap_dr),
        .shift_dr_o (shift_dr),
        .upd_dr_o   (upd_dr),
        .cap_ir_o   (cap_ir),
        .shift_ir_o (shift_ir),
        .upd_ir_o   (upd_ir)
    );

    logic [IR_LEN-1:0]  ir_q, ir_d, ir_sh_q, ir_sh_d;
    logic [BSR_LEN-1:0] bsr_q, bsr_d, upd_q, upd_d;
    logic               byp_q, byp_d;
    logic               sel_bsr, sel_id, extest, tdo_dr;

    assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
    assign extest  = (ir_q == OP_EXTEST);

`ifdef BSCAN_IDCODE_EN
    logic [ID_LEN-1:0] id_q, id_d;

    assign sel_id = (ir_q == OP_IDCODE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end
`else
    logic [ID_LEN-1:0] unused_idcode;

    assign sel_id        = 1'b0;
    assign unused_idcode = IDCODE_VAL;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ir_q    <= IR_RESET;
            ir_sh_q <= '0;
            bsr_q   <= '0;
            upd_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            ir_sh_q <= ir_sh_d;
            bsr_q   <= bsr_d;
            upd_q   <= upd_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        ir_d    = ir_q;
        ir_sh_d = ir_sh_q;
        bsr_d   = bsr_q;
        upd_d   = upd_q;
        byp_d   = byp_q;
`ifdef BSCAN_IDCODE_EN
        id_d    = id_q;
`endif
        if (cap_ir) begin
            ir_sh_d = IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sh_d = {TDI, ir_sh_q[IR_LEN-1:1]};
        end
        if (upd_ir) begin
            ir_d = ir_sh_q;
        end

        // Only the data register chosen by the active instruction captures or shifts
        if (cap_dr) begin
            if (sel_bsr) begin
                bsr_d = {CoreOut, PinIn};
            end
`ifdef BSCAN_IDCODE_EN
            else if (sel_id) begin
                id_d = IDCODE_VAL;
            end
`endif
            else begin
                byp_d = 1'b0;
            end
        end else if (shift_dr) begin
            if (sel_bsr) begin
                bsr_d = {TDI, bsr_q[BSR_LEN-1:1]};
            end
`ifdef BSCAN_IDCODE_EN
            else if (sel_id) begin
                id_d = {TDI, id_q[ID_LEN-1:1]};
            end
`endif
            else begin
                byp_d = TDI;
            end
        end
        if (upd_dr && sel_bsr) begin
            upd_d = bsr_q;
        end

        if (tlr_next) begin
            ir_d  = IR_RESET;
            upd_d = '0;
        end
    end

    always_comb begin
        tdo_dr = byp_q;
        if (sel_bsr) begin
            tdo_dr = bsr_q[0];
        end
`ifdef BSCAN_IDCODE_EN
        else if (sel_id) begin
            tdo_dr = id_q[0];
        end
`endif
    end

    assign TDO_En   = shift_ir | shift_dr;
    assign TDO      = shift_ir ? ir_sh_q[0] : (shift_dr & tdo_dr);
    assign TapState = state;

    assign CoreIn = extest ? upd_q[CELL_C:CELL_A] : PinIn;
    assign PinOut = extest ? upd_q[CELL_Y:CELL_X] : CoreOut;

endmodule
